// File: rtl/uart_pkg.sv
// Shared types and helpers for the tick-driven UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int MAX_DATA_W = 9;

    // Zero-extended inputs do not change the result, so one width serves every DATA_W.
    function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data, input int mode);
        logic w_xor;
        w_xor = ^data;
        return (mode == PARITY_ODD) ? ~w_xor : w_xor;
    endfunction

endpackage

// File: rtl/uart_tx_tick.sv
// UART transmitter advancing one bit per tick_en pulse: start, LSB-first data,
// optional parity, STOP_BITS stop bits. Handshake via tx_valid/tx_ready.
module uart_tx_tick
    import uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              tick_en,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam logic [3:0] LAST_IDX  = 4'(DATA_W - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_t       r_state;
    uart_state_t       w_state_next;
    logic              r_tx;
    logic              w_tx_next;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_next;
    logic              r_par;
    logic              w_par_next;
    logic [3:0]        r_idx;
    logic [3:0]        w_idx_next;
    logic              r_stop_cnt;
    logic              w_stop_cnt_next;
    logic              r_done;
    logic              w_done_next;
    logic              w_ready;

    assign w_ready  = (r_state == S_IDLE) && sys_rst_n;
    assign tx_ready = w_ready;
    assign tx       = r_tx;
    assign tx_busy  = (r_state != S_IDLE);
    assign tx_done  = r_done;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state    <= S_IDLE;
            r_tx       <= 1'b1;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_idx      <= '0;
            r_stop_cnt <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tx       <= w_tx_next;
            r_shift    <= w_shift_next;
            r_par      <= w_par_next;
            r_idx      <= w_idx_next;
            r_stop_cnt <= w_stop_cnt_next;
            r_done     <= w_done_next;
        end
    end

    // The shift register is consumed from bit 0, so the line always takes r_shift[0].
    always_comb begin
        w_state_next    = r_state;
        w_tx_next       = r_tx;
        w_shift_next    = r_shift;
        w_par_next      = r_par;
        w_idx_next      = r_idx;
        w_stop_cnt_next = r_stop_cnt;
        w_done_next     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (tx_valid && w_ready) begin
                    w_shift_next = tx_data;
                    w_par_next   = parity_bit(MAX_DATA_W'(tx_data), PARITY);
                    w_state_next = S_ARM;
                end
            end
            S_ARM: begin
                if (tick_en) begin
                    w_state_next = S_START;
                    w_tx_next    = 1'b0;
                end
            end
            S_START: begin
                if (tick_en) begin
                    w_state_next = S_DATA;
                    w_tx_next    = r_shift[0];
                    w_shift_next = r_shift >> 1;
                    w_idx_next   = '0;
                end
            end
            S_DATA: begin
                if (tick_en) begin
                    if (r_idx < LAST_IDX) begin
                        w_tx_next    = r_shift[0];
                        w_shift_next = r_shift >> 1;
                        w_idx_next   = r_idx + 4'd1;
                    end else if (PARITY != PARITY_NONE) begin
                        w_state_next = S_PARITY;
                        w_tx_next    = r_par;
                    end else begin
                        w_state_next    = S_STOP;
                        w_tx_next       = 1'b1;
                        w_stop_cnt_next = 1'b0;
                    end
                end
            end
            S_PARITY: begin
                if (tick_en) begin
                    w_state_next    = S_STOP;
                    w_tx_next       = 1'b1;
                    w_stop_cnt_next = 1'b0;
                end
            end
            S_STOP: begin
                if (tick_en) begin
                    if (r_stop_cnt == LAST_STOP) begin
                        w_state_next = S_IDLE;
                        w_tx_next    = 1'b1;
                        w_done_next  = 1'b1;
                    end else begin
                        w_stop_cnt_next = r_stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_tick.sv
// Four transmitters (8N1, 8O1, 8E1, 8N2) checked every cycle against a frame-level
// line model, plus hand-computed literal expectations for the key scenarios.
module tb_uart_tx_tick;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic       sys_rst_n;
    int         ratio = 10;
    int         tick_cnt = 0;
    bit         tick_auto = 1'b1;
    logic       tick_man = 1'b0;
    logic       tick_en;
    logic [3:0] tx_valid;
    logic [3:0] tx_ready;
    logic [3:0] tx_line;
    logic [3:0] tx_busy;
    logic [3:0] tx_done;
    logic [7:0] tx_data [4];

    localparam int P_PAR [4]  = '{0, 1, 2, 0};
    localparam int P_STOP [4] = '{1, 1, 1, 2};

    int n_checks = 0;
    int n_fail   = 0;

    always @(posedge sys_clk) tick_cnt <= (tick_cnt >= ratio - 1) ? 0 : tick_cnt + 1;
    assign tick_en = tick_auto ? (tick_cnt == ratio - 1) : tick_man;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            uart_tx_tick #(
                .DATA_W   (8),
                .PARITY   ((gi == 1) ? 1 : ((gi == 2) ? 2 : 0)),
                .STOP_BITS((gi == 3) ? 2 : 1)
            ) u_dut (
                .sys_clk  (sys_clk),
                .sys_rst_n(sys_rst_n),
                .tick_en  (tick_en),
                .tx_data  (tx_data[gi]),
                .tx_valid (tx_valid[gi]),
                .tx_ready (tx_ready[gi]),
                .tx       (tx_line[gi]),
                .tx_busy  (tx_busy[gi]),
                .tx_done  (tx_done[gi])
            );
        end
    endgenerate

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Line model: a frame is a list of levels; each tick after acceptance puts the
    // next level on the line, and the tick after the last level ends the frame.
    function automatic logic [12:0] frame_of(input logic [7:0] d, input int par);
        logic [12:0] f = '1;
        int ones = $countones(d);
        f[0] = 1'b0;
        for (int b = 0; b < 8; b++) f[1+b] = d[b];
        if (par == 1) f[9] = (ones % 2 == 0);
        if (par == 2) f[9] = (ones % 2 == 1);
        return f;
    endfunction

    bit          m_busy [4] = '{0, 0, 0, 0};
    bit          m_tx [4]   = '{1, 1, 1, 1};
    bit          m_done [4] = '{0, 0, 0, 0};
    logic [12:0] m_frame [4];
    int          m_len [4]  = '{0, 0, 0, 0};
    int          m_pos [4]  = '{0, 0, 0, 0};

    always @(posedge sys_clk) begin
        for (int i = 0; i < 4; i++) begin
            m_done[i] <= 1'b0;
            if (!sys_rst_n) begin
                m_busy[i] <= 1'b0;
                m_tx[i]   <= 1'b1;
            end else if (!m_busy[i]) begin
                if (tx_valid[i]) begin
                    m_frame[i] <= frame_of(tx_data[i], P_PAR[i]);
                    m_len[i]   <= 9 + ((P_PAR[i] != 0) ? 1 : 0) + P_STOP[i];
                    m_pos[i]   <= 0;
                    m_busy[i]  <= 1'b1;
                end
            end else if (tick_en) begin
                if (m_pos[i] < m_len[i]) begin
                    m_tx[i]  <= m_frame[i][m_pos[i]];
                    m_pos[i] <= m_pos[i] + 1;
                end else begin
                    m_busy[i] <= 1'b0;
                    m_done[i] <= 1'b1;
                    m_tx[i]   <= 1'b1;
                end
            end
        end
    end

    always @(negedge sys_clk) begin
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("model_tx[%0d]", i), 32'(tx_line[i]), 32'(m_tx[i]));
            chk($sformatf("model_busy[%0d]", i), 32'(tx_busy[i]), 32'(m_busy[i]));
            chk($sformatf("model_done[%0d]", i), 32'(tx_done[i]), 32'(m_done[i]));
            chk($sformatf("model_ready[%0d]", i), 32'(tx_ready[i]), 32'(!m_busy[i] && sys_rst_n));
        end
    end

    task automatic send(input logic [3:0] mask, input logic [7:0] d);
        @(negedge sys_clk);
        for (int i = 0; i < 4; i++) if (mask[i]) tx_data[i] = d;
        tx_valid = mask;
        $display("send 0x%02h to channels %b", d, mask);
        @(posedge sys_clk);
        #1 tx_valid = 4'b0000;
    endtask

    task automatic wait_tick();
        for (int n = 0; n < 100; n++) begin
            @(negedge sys_clk);
            if (tick_en) begin
                @(posedge sys_clk);
                return;
            end
        end
        chk("wait_tick_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 3000; n++) begin
            if (!(m_busy[0] || m_busy[1] || m_busy[2] || m_busy[3])) return;
            @(negedge sys_clk);
        end
        chk("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    int exp55 [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    int exp81 [10] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1};

    initial begin
        int second_start;
        int ready_cyc;
        sys_rst_n = 1'b0;
        tx_valid  = 4'b0000;
        for (int i = 0; i < 4; i++) tx_data[i] = 8'h00;

        repeat (3) @(negedge sys_clk);
        chk("reset_tx", 32'(tx_line), 32'hF);
        chk("reset_busy", 32'(tx_busy), 32'h0);
        chk("reset_done", 32'(tx_done), 32'h0);
        chk("reset_ready", 32'(tx_ready), 32'h0);
        #1 sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("ready_after_reset", 32'(tx_ready), 32'hF);

        // 0x55 on every channel; literal line levels on the 8N1 channel
        send(4'hF, 8'h55);
        wait_tick();
        for (int k = 0; k < 10; k++) begin
            @(negedge sys_clk);
            chk($sformatf("line55_bit%0d", k), 32'(tx_line[0]), 32'(exp55[k]));
            repeat (9) @(negedge sys_clk);
        end
        chk("done_before_100", 32'(tx_done[0]), 32'd0);
        @(negedge sys_clk);
        chk("done_at_100", 32'(tx_done[0]), 32'd1);
        wait_idle();

        // parity bit sits in bit slot 9, sampled mid-period
        send(4'b0110, 8'h07);
        wait_tick();
        repeat (96) @(negedge sys_clk);
        chk("odd_par_07", 32'(tx_line[1]), 32'd0);
        chk("even_par_07", 32'(tx_line[2]), 32'd1);
        wait_idle();
        send(4'b0110, 8'h00);
        wait_tick();
        repeat (96) @(negedge sys_clk);
        chk("odd_par_00", 32'(tx_line[1]), 32'd1);
        chk("even_par_00", 32'(tx_line[2]), 32'd0);
        wait_idle();

        // back-to-back on the two-stop channel with tx_valid held high
        @(negedge sys_clk);
        tx_data[3]  = 8'hA3;
        tx_valid[3] = 1'b1;
        $display("send 0xa3 then 0x3c back-to-back on channel 3");
        @(posedge sys_clk);
        #1 tx_data[3] = 8'h3C;
        wait_tick();
        second_start = -1;
        ready_cyc    = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge sys_clk);
            if (tx_ready[3]) ready_cyc++;
            if (c >= 90 && tx_line[3] == 1'b0) begin
                second_start = c;
                break;
            end
        end
        tx_valid[3] = 1'b0;
        chk("b2b_start_gap", 32'(second_start - 90), 32'd30);
        chk("b2b_ready_cycles", 32'(ready_cyc), 32'd1);
        wait_idle();

        // tick coincident with the accepting edge must not start the frame
        tick_auto = 1'b0;
        @(negedge sys_clk);
        tx_data[0]  = 8'h5A;
        tx_valid[0] = 1'b1;
        tick_man    = 1'b1;
        $display("send 0x5a to channel 0 with tick on accept");
        @(posedge sys_clk);
        #1 tx_valid = 4'b0000;
        tick_man = 1'b0;
        @(negedge sys_clk);
        chk("accept_tick_tx", 32'(tx_line[0]), 32'd1);
        chk("accept_tick_busy", 32'(tx_busy[0]), 32'd1);
        repeat (2) @(negedge sys_clk);
        tick_man = 1'b1;
        @(posedge sys_clk);
        #1 tick_man = 1'b0;
        @(negedge sys_clk);
        chk("start_after_tick", 32'(tx_line[0]), 32'd0);
        tick_auto = 1'b1;
        wait_idle();

        // reset during data bit 3, then a clean 0xFF frame
        send(4'b0001, 8'h55);
        wait_tick();
        repeat (45) @(negedge sys_clk);
        #1 sys_rst_n = 1'b0;
        @(negedge sys_clk);
        chk("midrst_tx", 32'(tx_line[0]), 32'd1);
        chk("midrst_busy", 32'(tx_busy[0]), 32'd0);
        chk("midrst_done", 32'(tx_done[0]), 32'd0);
        #1 sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("midrst_ready", 32'(tx_ready[0]), 32'd1);
        send(4'b0001, 8'hFF);
        wait_tick();
        @(negedge sys_clk);
        chk("ff_start", 32'(tx_line[0]), 32'd0);
        repeat (10) @(negedge sys_clk);
        chk("ff_d0", 32'(tx_line[0]), 32'd1);
        wait_idle();

        // divider ratio 1: one bit per cycle
        ratio = 1;
        repeat (2) @(negedge sys_clk);
        send(4'b0001, 8'h81);
        @(negedge sys_clk);
        chk("r1_arm_tx", 32'(tx_line[0]), 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge sys_clk);
            chk($sformatf("r1_bit%0d", k), 32'(tx_line[0]), 32'(exp81[k]));
        end
        @(negedge sys_clk);
        chk("r1_done", 32'(tx_done[0]), 32'd1);
        wait_idle();

        repeat (5) @(negedge sys_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
